pcie_logic_master_fsm: RTL and testbench

- Central control state machine for the PCIe-style two-virtual-channel datapath.
  - The datapath is a 6-bit main FIFO (MF), feeding VC0/VC1 FIFOs, feeding destination FIFOs D0/D1.
- Sequences reset, threshold configuration and run phases.
- Distributes the registered almost-full/almost-empty thresholds (umbrales) to all five FIFOs.
- Reports global status as active_out, idle_out and error_out, plus a sticky per-FIFO overflow record.

---
 rtl/pcie_logic_master_fsm.sv | 104 ++++++++++
 tb/tb_pcie_logic_master_fsm.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pcie_logic_master_fsm.sv
`default_nettype none
// ============================================================================
// Module  : pcie_logic_master_fsm
// Brief   : Master control FSM for the two-VC datapath; owns FIFO thresholds
//           and global status (active / idle / sticky overflow error).
// Revision: 1.0 - initial release
// ============================================================================
module pcie_logic_master_fsm #(
    parameter logic [1:0] DEF_UMBRAL_MF = 2'd1,
    parameter logic [3:0] DEF_UMBRAL_VC = 4'd4,
    parameter logic [1:0] DEF_UMBRAL_D  = 2'd1
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       init,
    input  logic [1:0] umbralMF_in,
    input  logic [3:0] umbralVC0_in,
    input  logic [3:0] umbralVC1_in,
    input  logic [1:0] umbralD0_in,
    input  logic [1:0] umbralD1_in,
    input  logic [4:0] fifo_empty,
    input  logic [4:0] fifo_overflow,
    output logic [1:0] umbralMF_out,
    output logic [3:0] umbralVC0_out,
    output logic [3:0] umbralVC1_out,
    output logic [1:0] umbralD0_out,
    output logic [1:0] umbralD1_out,
    output logic       active_out,
    output logic       idle_out,
    output logic       error_out,
    output logic [4:0] error_fifo,
    output logic [4:0] state
);

    typedef enum logic [4:0] {
        S_RESET  = 5'b00001,
        S_INIT   = 5'b00010,
        S_IDLE   = 5'b00100,
        S_ACTIVE = 5'b01000,
        S_ERROR  = 5'b10000
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_all_empty;
    logic   w_overflow;
    logic   w_load;

    assign w_all_empty = &fifo_empty;
    assign w_overflow  = |fifo_overflow;
    // Thresholds track the inputs while configuring, but an overflow edge
    // goes straight to ERROR without touching them.
    assign w_load      = (r_state == S_INIT) && !w_overflow;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RESET:  w_state_next = init ? S_INIT : S_IDLE;
            S_INIT, S_IDLE, S_ACTIVE: begin
                if (w_overflow)       w_state_next = S_ERROR;
                else if (init)        w_state_next = S_INIT;
                else if (w_all_empty) w_state_next = S_IDLE;
                else                  w_state_next = S_ACTIVE;
            end
            S_ERROR:  w_state_next = S_ERROR;
            default:  w_state_next = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_state       <= S_RESET;
            umbralMF_out  <= DEF_UMBRAL_MF;
            umbralVC0_out <= DEF_UMBRAL_VC;
            umbralVC1_out <= DEF_UMBRAL_VC;
            umbralD0_out  <= DEF_UMBRAL_D;
            umbralD1_out  <= DEF_UMBRAL_D;
            active_out    <= 1'b0;
            idle_out      <= 1'b0;
            error_out     <= 1'b0;
            error_fifo    <= 5'b0;
        end else begin
            r_state    <= w_state_next;
            // Status flags are decoded from the next state so they move with it.
            idle_out   <= (w_state_next == S_IDLE);
            active_out <= (w_state_next == S_ACTIVE);
            error_out  <= (w_state_next == S_ERROR);
            if (r_state != S_RESET) begin
                error_fifo <= error_fifo | fifo_overflow;
            end
            if (w_load) begin
                umbralMF_out  <= umbralMF_in;
                umbralVC0_out <= umbralVC0_in;
                umbralVC1_out <= umbralVC1_in;
                umbralD0_out  <= umbralD0_in;
                umbralD1_out  <= umbralD1_in;
            end
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pcie_logic_master_fsm.sv
`default_nettype none
// ============================================================================
// Module  : tb_pcie_logic_master_fsm
// Brief   : Directed self-checking bench for pcie_logic_master_fsm.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pcie_logic_master_fsm;

    logic       clk;
    logic       reset_L;
    logic       init;
    logic [1:0] umbralMF_in;
    logic [3:0] umbralVC0_in;
    logic [3:0] umbralVC1_in;
    logic [1:0] umbralD0_in;
    logic [1:0] umbralD1_in;
    logic [4:0] fifo_empty;
    logic [4:0] fifo_overflow;
    logic [1:0] umbralMF_out;
    logic [3:0] umbralVC0_out;
    logic [3:0] umbralVC1_out;
    logic [1:0] umbralD0_out;
    logic [1:0] umbralD1_out;
    logic       active_out;
    logic       idle_out;
    logic       error_out;
    logic [4:0] error_fifo;
    logic [4:0] state;

    int checks   = 0;
    int failures = 0;

    localparam logic [4:0] c_st_reset  = 5'b00001;
    localparam logic [4:0] c_st_init   = 5'b00010;
    localparam logic [4:0] c_st_idle   = 5'b00100;
    localparam logic [4:0] c_st_active = 5'b01000;
    localparam logic [4:0] c_st_error  = 5'b10000;

    pcie_logic_master_fsm dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .init          (init),
        .umbralMF_in   (umbralMF_in),
        .umbralVC0_in  (umbralVC0_in),
        .umbralVC1_in  (umbralVC1_in),
        .umbralD0_in   (umbralD0_in),
        .umbralD1_in   (umbralD1_in),
        .fifo_empty    (fifo_empty),
        .fifo_overflow (fifo_overflow),
        .umbralMF_out  (umbralMF_out),
        .umbralVC0_out (umbralVC0_out),
        .umbralVC1_out (umbralVC1_out),
        .umbralD0_out  (umbralD0_out),
        .umbralD1_out  (umbralD1_out),
        .active_out    (active_out),
        .idle_out      (idle_out),
        .error_out     (error_out),
        .error_fifo    (error_fifo),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic [4:0] st,
                                input logic act, input logic idl, input logic err);
        check({tag, ".state"},  {27'b0, state},      {27'b0, st});
        check({tag, ".active"}, {31'b0, active_out}, {31'b0, act});
        check({tag, ".idle"},   {31'b0, idle_out},   {31'b0, idl});
        check({tag, ".error"},  {31'b0, error_out},  {31'b0, err});
    endtask

    task automatic check_thr(input string tag, input logic [1:0] mf, input logic [3:0] vc0,
                             input logic [3:0] vc1, input logic [1:0] d0, input logic [1:0] d1);
        check({tag, ".mf"},  {30'b0, umbralMF_out},  {30'b0, mf});
        check({tag, ".vc0"}, {28'b0, umbralVC0_out}, {28'b0, vc0});
        check({tag, ".vc1"}, {28'b0, umbralVC1_out}, {28'b0, vc1});
        check({tag, ".d0"},  {30'b0, umbralD0_out},  {30'b0, d0});
        check({tag, ".d1"},  {30'b0, umbralD1_out},  {30'b0, d1});
    endtask

    initial begin
        reset_L       = 1'b0;
        init          = 1'b0;
        umbralMF_in   = 2'd2;
        umbralVC0_in  = 4'd9;
        umbralVC1_in  = 4'd7;
        umbralD0_in   = 2'd2;
        umbralD1_in   = 2'd3;
        fifo_empty    = 5'b11111;
        fifo_overflow = 5'b00000;

        // Reset held two edges: defaults and RESET state.
        tick();
        tick();
        check_status("rst", c_st_reset, 1'b0, 1'b0, 1'b0);
        check("rst.efifo", {27'b0, error_fifo}, 32'h0);
        check_thr("rst", 2'd1, 4'd4, 4'd4, 2'd1, 2'd1);

        // Release with all empty -> IDLE; thresholds stay at defaults.
        reset_L = 1'b1;
        tick();
        check_status("idle0", c_st_idle, 1'b0, 1'b1, 1'b0);
        check_thr("idle0", 2'd1, 4'd4, 4'd4, 2'd1, 2'd1);

        // Configuration: init high three edges, inputs steady.
        init = 1'b1;
        tick();
        check_status("init1", c_st_init, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_status("init3", c_st_init, 1'b0, 1'b0, 1'b0);
        init = 1'b0;
        tick();
        check_status("init_exit", c_st_idle, 1'b0, 1'b1, 1'b0);
        check_thr("cfg", 2'd2, 4'd9, 4'd7, 2'd2, 2'd3);

        // Thresholds held once out of INIT even though inputs change.
        umbralVC0_in = 4'd0;
        umbralD1_in  = 2'd0;
        tick();
        check_thr("hold", 2'd2, 4'd9, 4'd7, 2'd2, 2'd3);

        // MF non-empty -> ACTIVE, then drained -> IDLE.
        fifo_empty = 5'b11110;
        tick();
        check_status("act", c_st_active, 1'b1, 1'b0, 1'b0);
        fifo_empty = 5'b11111;
        tick();
        check_status("drain", c_st_idle, 1'b0, 1'b1, 1'b0);

        // Back to ACTIVE, then VC1 overflow -> ERROR.
        fifo_empty = 5'b01111;
        tick();
        check_status("act2", c_st_active, 1'b1, 1'b0, 1'b0);
        fifo_overflow = 5'b00100;
        tick();
        check_status("ovf_vc1", c_st_error, 1'b0, 1'b0, 1'b1);
        check("ovf_vc1.efifo", {27'b0, error_fifo}, 32'h04);

        // ERROR is absorbing: init and empty flags ignored, overflow still recorded.
        fifo_overflow = 5'b00000;
        init          = 1'b1;
        fifo_empty    = 5'b11111;
        tick();
        check_status("err_hold", c_st_error, 1'b0, 1'b0, 1'b1);
        fifo_overflow = 5'b01000;
        tick();
        check("ovf_d0.efifo", {27'b0, error_fifo}, 32'h0C);
        fifo_overflow = 5'b00000;
        fifo_empty    = 5'b10101;
        tick();
        check_status("err_hold2", c_st_error, 1'b0, 1'b0, 1'b1);
        check("err_hold2.efifo", {27'b0, error_fifo}, 32'h0C);
        check_thr("err_thr", 2'd2, 4'd9, 4'd7, 2'd2, 2'd3);

        // One reset edge from ERROR clears everything.
        reset_L    = 1'b0;
        init       = 1'b0;
        fifo_empty = 5'b11111;
        tick();
        check_status("rst2", c_st_reset, 1'b0, 1'b0, 1'b0);
        check("rst2.efifo", {27'b0, error_fifo}, 32'h0);
        check_thr("rst2", 2'd1, 4'd4, 4'd4, 2'd1, 2'd1);

        // Overflow while leaving RESET is ignored.
        reset_L       = 1'b1;
        fifo_overflow = 5'b00010;
        tick();
        check_status("rst_ovf", c_st_idle, 1'b0, 1'b1, 1'b0);
        check("rst_ovf.efifo", {27'b0, error_fifo}, 32'h0);

        // Same edge init + MF overflow: ERROR wins, thresholds not loaded.
        init          = 1'b1;
        fifo_overflow = 5'b00001;
        umbralVC0_in  = 4'd5;
        umbralMF_in   = 2'd3;
        tick();
        check_status("init_ovf", c_st_error, 1'b0, 1'b0, 1'b1);
        check("init_ovf.efifo", {27'b0, error_fifo}, 32'h01);
        check_thr("init_ovf", 2'd1, 4'd4, 4'd4, 2'd1, 2'd1);

        // Stays in ERROR with init still high; thresholds untouched.
        fifo_overflow = 5'b00000;
        tick();
        check_status("init_ovf2", c_st_error, 1'b0, 1'b0, 1'b1);
        check_thr("init_ovf2", 2'd1, 4'd4, 4'd4, 2'd1, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
